// File: rtl/mini16sc_pkg.sv
// mini16sc_pkg
// Shared constants for the mini16sc host boot path: header command codes,
// header field positions and the boot controller state encodings.
// No ports (package).
package mini16sc_pkg;

    // Header command codes, carried in the top two bits of a header word.
    localparam logic [1:0] CMD_LOAD_I = 2'b00;
    localparam logic [1:0] CMD_LOAD_D = 2'b01;
    localparam logic [1:0] CMD_RUN    = 2'b10;
    localparam logic [1:0] CMD_HALT   = 2'b11;

    // Header field positions.
    localparam int CMD_MSB = 15;
    localparam int CMD_LSB = 14;
    localparam int CNT_MSB = 13;

    // Boot controller state encodings.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/mini16sc_dmem_arb.sv
// mini16sc_dmem_arb
// Data memory write-port arbiter. The loader owns the port whenever it is
// writing; otherwise the CPU store port passes straight through. A CPU store
// that coincides with a loader write is dropped and latched in collide_o,
// which only reset clears.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   ld_we_i, ld_addr_i, ld_data_i      loader write request
//   cpu_we_i, cpu_addr_i, cpu_data_i   CPU store request
//   d_we_o, d_addr_o, d_data_o         shared data memory write port
//   collide_o                          sticky dropped-store flag
module mini16sc_dmem_arb #(
    parameter int WIDTH_D = 16,
    parameter int DEPTH_D = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ld_we_i,
    input  logic [DEPTH_D-1:0] ld_addr_i,
    input  logic [WIDTH_D-1:0] ld_data_i,
    input  logic               cpu_we_i,
    input  logic [DEPTH_D-1:0] cpu_addr_i,
    input  logic [WIDTH_D-1:0] cpu_data_i,
    output logic               d_we_o,
    output logic [DEPTH_D-1:0] d_addr_o,
    output logic [WIDTH_D-1:0] d_data_o,
    output logic               collide_o
);

    logic collide_q;

    assign d_we_o    = ld_we_i | cpu_we_i;
    assign d_addr_o  = ld_we_i ? ld_addr_i : cpu_addr_i;
    assign d_data_o  = ld_we_i ? ld_data_i : cpu_data_i;
    assign collide_o = collide_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            collide_q <= 1'b0;
        end else if (ld_we_i && cpu_we_i) begin
            collide_q <= 1'b1;
        end
    end

endmodule

// File: rtl/mini16sc_boot_ctrl.sv
// mini16sc_boot_ctrl
// Host-side boot and run controller for the mini16sc CPU. Decodes a 16-bit
// host word stream (header, address, data words), loads instruction or data
// memory, and drives the CPU soft reset from a run flag.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   s_valid, s_ready, s_data        host word stream (never back-pressured)
//   soft_reset, running             CPU halt control / run status
//   i_w_addr, i_w_data, i_we        instruction memory write port (registered)
//   cpu_d_w_addr/data, cpu_d_we     CPU data memory store port
//   d_w_addr, d_w_data, d_we        shared data memory write port
//   busy                            load in progress (ADDR or DATA)
//   collide                         sticky: a CPU store was dropped
module mini16sc_boot_ctrl
    import mini16sc_pkg::*;
#(
    parameter int WIDTH_I = 16,
    parameter int WIDTH_D = 16,
    parameter int DEPTH_I = 8,
    parameter int DEPTH_D = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [15:0]        s_data,
    output logic               soft_reset,
    output logic [DEPTH_I-1:0] i_w_addr,
    output logic [WIDTH_I-1:0] i_w_data,
    output logic               i_we,
    input  logic [DEPTH_D-1:0] cpu_d_w_addr,
    input  logic [WIDTH_D-1:0] cpu_d_w_data,
    input  logic               cpu_d_we,
    output logic [DEPTH_D-1:0] d_w_addr,
    output logic [WIDTH_D-1:0] d_w_data,
    output logic               d_we,
    output logic               running,
    output logic               busy,
    output logic               collide
);

    logic [1:0]         state_q,    state_d;
    logic               run_q,      run_d;
    logic               tgt_dmem_q, tgt_dmem_d;  // 1: load targets data memory
    logic [CNT_MSB:0]   cnt_q,      cnt_d;       // words remaining minus 1
    logic [DEPTH_I-1:0] ia_q,       ia_d;        // next instruction address
    logic [DEPTH_D-1:0] da_q,       da_d;        // next data address
    logic               i_we_q,     i_we_d;
    logic [DEPTH_I-1:0] i_w_addr_q, i_w_addr_d;
    logic [WIDTH_I-1:0] i_w_data_q, i_w_data_d;
    logic               ld_we_q,    ld_we_d;
    logic [DEPTH_D-1:0] ld_addr_q,  ld_addr_d;
    logic [WIDTH_D-1:0] ld_data_q,  ld_data_d;

    logic       accept;
    logic [1:0] cmd;

    // Ready is held low only while reset is asserted.
    assign s_ready    = !reset;
    assign accept     = s_valid && s_ready;
    assign cmd        = s_data[CMD_MSB:CMD_LSB];

    assign running    = run_q;
    assign soft_reset = !run_q;
    assign busy       = (state_q != ST_IDLE);
    assign i_we       = i_we_q;
    assign i_w_addr   = i_w_addr_q;
    assign i_w_data   = i_w_data_q;

    always_comb begin
        state_d    = state_q;
        run_d      = run_q;
        tgt_dmem_d = tgt_dmem_q;
        cnt_d      = cnt_q;
        ia_d       = ia_q;
        da_d       = da_q;
        i_we_d     = 1'b0;
        i_w_addr_d = i_w_addr_q;
        i_w_data_d = i_w_data_q;
        ld_we_d    = 1'b0;
        ld_addr_d  = ld_addr_q;
        ld_data_d  = ld_data_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (cmd)
                        CMD_RUN:  run_d = 1'b1;
                        CMD_HALT: run_d = 1'b0;
                        CMD_LOAD_I, CMD_LOAD_D: begin
                            // Loading implies a halt so the CPU never
                            // executes a half-written image.
                            tgt_dmem_d = (cmd == CMD_LOAD_D);
                            cnt_d      = s_data[CNT_MSB:0];
                            run_d      = 1'b0;
                            state_d    = ST_ADDR;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end

            ST_ADDR: begin
                if (accept) begin
                    ia_d    = s_data[DEPTH_I-1:0];
                    da_d    = s_data[DEPTH_D-1:0];
                    state_d = ST_DATA;
                end
            end

            ST_DATA: begin
                if (accept) begin
                    if (tgt_dmem_q) begin
                        ld_we_d   = 1'b1;
                        ld_addr_d = da_q;
                        ld_data_d = s_data[WIDTH_D-1:0];
                        da_d      = da_q + 1'b1;   // wraps silently
                    end else begin
                        i_we_d     = 1'b1;
                        i_w_addr_d = ia_q;
                        i_w_data_d = s_data[WIDTH_I-1:0];
                        ia_d       = ia_q + 1'b1;  // wraps silently
                    end
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            run_q      <= 1'b0;
            i_we_q     <= 1'b0;
            i_w_addr_q <= '0;
            i_w_data_q <= '0;
            ld_we_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            i_we_q     <= i_we_d;
            i_w_addr_q <= i_w_addr_d;
            i_w_data_q <= i_w_data_d;
            ld_we_q    <= ld_we_d;
        end
    end

    // Datapath registers carry no reset; they are only observed behind
    // a reset-cleared state or write enable.
    always_ff @(posedge clk) begin
        tgt_dmem_q <= tgt_dmem_d;
        cnt_q      <= cnt_d;
        ia_q       <= ia_d;
        da_q       <= da_d;
        ld_addr_q  <= ld_addr_d;
        ld_data_q  <= ld_data_d;
    end

    mini16sc_dmem_arb #(
        .WIDTH_D (WIDTH_D),
        .DEPTH_D (DEPTH_D)
    ) u_dmem_arb (
        .clk        (clk),
        .reset      (reset),
        .ld_we_i    (ld_we_q),
        .ld_addr_i  (ld_addr_q),
        .ld_data_i  (ld_data_q),
        .cpu_we_i   (cpu_d_we),
        .cpu_addr_i (cpu_d_w_addr),
        .cpu_data_i (cpu_d_w_data),
        .d_we_o     (d_we),
        .d_addr_o   (d_w_addr),
        .d_data_o   (d_w_data),
        .collide_o  (collide)
    );

endmodule

// File: tb/tb_mini16sc_boot_ctrl.sv
module tb_mini16sc_boot_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic        soft_reset;
    logic [7:0]  i_w_addr;
    logic [15:0] i_w_data;
    logic        i_we;
    logic [7:0]  cpu_d_w_addr;
    logic [15:0] cpu_d_w_data;
    logic        cpu_d_we;
    logic [7:0]  d_w_addr;
    logic [15:0] d_w_data;
    logic        d_we;
    logic        running;
    logic        busy;
    logic        collide;

    int n_vec  = 0;
    int n_fail = 0;
    int unsigned cyc = 0;

    typedef struct {
        int unsigned due;
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;
    wr_t q[$];

    typedef struct {
        logic        v;
        logic [15:0] w;
        bit          wr;
        logic [7:0]  wa;
        logic        run;
        logic        bsy;
    } vec_t;
    vec_t tv[15];

    mini16sc_boot_ctrl #(
        .WIDTH_I (16),
        .WIDTH_D (16),
        .DEPTH_I (8),
        .DEPTH_D (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .soft_reset   (soft_reset),
        .i_w_addr     (i_w_addr),
        .i_w_data     (i_w_data),
        .i_we         (i_we),
        .cpu_d_w_addr (cpu_d_w_addr),
        .cpu_d_w_data (cpu_d_w_data),
        .cpu_d_we     (cpu_d_we),
        .d_w_addr     (d_w_addr),
        .d_w_data     (d_w_data),
        .d_we         (d_we),
        .running      (running),
        .busy         (busy),
        .collide      (collide)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Drive one host word at a falling edge; expected instruction writes are
    // queued with the cycle in which they must appear.
    task automatic send(input logic v, input logic [15:0] w, input bit wr, input logic [7:0] wa);
        s_valid = v;
        s_data  = w;
        if (wr) q.push_back('{cyc + 1, wa, w});
        @(negedge clk);
    endtask

    task automatic cpu(input logic we, input logic [7:0] a, input logic [15:0] d);
        cpu_d_we     = we;
        cpu_d_w_addr = a;
        cpu_d_w_data = d;
    endtask

    // Instruction write scoreboard.
    always @(negedge clk) begin
        wr_t e;
        if (i_we === 1'b1) begin
            if (q.size() == 0) begin
                chk("i_we_unexpected", {31'b0, i_we}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("i_w_addr", {24'b0, i_w_addr}, {24'b0, e.a});
                chk("i_w_data", {16'b0, i_w_data}, {16'b0, e.d});
                chk("i_we_cycle", cyc, e.due);
            end
        end else if (q.size() != 0 && q[0].due <= cyc) begin
            chk("i_we_missing", {31'b0, i_we}, 32'd1);
            void'(q.pop_front());
        end
    end

    initial begin
        //        v     word       wr  wa      run   busy
        tv[0]  = '{1'b0, 16'h0000, 0, 8'h00, 1'b0, 1'b0};
        tv[1]  = '{1'b1, 16'h8000, 0, 8'h00, 1'b1, 1'b0};  // RUN
        tv[2]  = '{1'b1, 16'hC000, 0, 8'h00, 1'b0, 1'b0};  // HALT
        tv[3]  = '{1'b1, 16'h8000, 0, 8'h00, 1'b1, 1'b0};  // RUN
        tv[4]  = '{1'b1, 16'h0002, 0, 8'h00, 1'b0, 1'b1};  // LOAD_I x3, implicit halt
        tv[5]  = '{1'b1, 16'h0010, 0, 8'h00, 1'b0, 1'b1};  // address
        tv[6]  = '{1'b1, 16'hAAAA, 1, 8'h10, 1'b0, 1'b1};
        tv[7]  = '{1'b1, 16'hBBBB, 1, 8'h11, 1'b0, 1'b1};
        tv[8]  = '{1'b1, 16'hCCCC, 1, 8'h12, 1'b0, 1'b0};  // busy falls with last write
        tv[9]  = '{1'b1, 16'h0001, 0, 8'h00, 1'b0, 1'b1};  // LOAD_I x2
        tv[10] = '{1'b1, 16'hABFF, 0, 8'h00, 1'b0, 1'b1};  // address 0xFF, upper bits ignored
        tv[11] = '{1'b1, 16'h1111, 1, 8'hFF, 1'b0, 1'b1};
        tv[12] = '{1'b1, 16'h2222, 1, 8'h00, 1'b0, 1'b0};  // wraps to 0x00
        tv[13] = '{1'b0, 16'h8000, 0, 8'h00, 1'b0, 1'b0};  // not valid: ignored
        tv[14] = '{1'b1, 16'h8000, 0, 8'h00, 1'b1, 1'b0};  // RUN

        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = 16'h0000;
        cpu(1'b0, 8'h00, 16'h0000);
        repeat (3) @(negedge clk);
        chk("reset_s_ready", {31'b0, s_ready}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_soft_reset", {31'b0, soft_reset}, 32'd1);
        chk("rst_running",    {31'b0, running},    32'd0);
        chk("rst_busy",       {31'b0, busy},       32'd0);
        chk("rst_s_ready",    {31'b0, s_ready},    32'd1);
        chk("rst_i_we",       {31'b0, i_we},       32'd0);
        chk("rst_d_we",       {31'b0, d_we},       32'd0);
        chk("rst_collide",    {31'b0, collide},    32'd0);
        chk("rst_i_w_addr",   {24'b0, i_w_addr},   32'd0);
        chk("rst_i_w_data",   {16'b0, i_w_data},   32'd0);

        for (int i = 0; i < 15; i++) begin
            send(tv[i].v, tv[i].w, tv[i].wr, tv[i].wa);
            chk($sformatf("v%0d_running", i),    {31'b0, running},    {31'b0, tv[i].run});
            chk($sformatf("v%0d_soft_reset", i), {31'b0, soft_reset}, {31'b0, !tv[i].run});
            chk($sformatf("v%0d_busy", i),       {31'b0, busy},       {31'b0, tv[i].bsy});
        end

        // Reset in the middle of a 4-word load.
        send(1'b1, 16'h0003, 0, 8'h00);
        send(1'b1, 16'h0020, 0, 8'h00);
        send(1'b1, 16'h5555, 1, 8'h20);
        chk("mid_busy_before", {31'b0, busy}, 32'd1);
        reset   = 1'b1;
        s_valid = 1'b1;
        s_data  = 16'h6666;
        #1;
        chk("mid_s_ready_in_reset", {31'b0, s_ready}, 32'd0);
        @(negedge clk);
        reset   = 1'b0;
        s_valid = 1'b0;
        chk("mid_busy_after",    {31'b0, busy},    32'd0);
        chk("mid_i_we_after",    {31'b0, i_we},    32'd0);
        chk("mid_running_after", {31'b0, running}, 32'd0);
        repeat (2) send(1'b0, 16'h0000, 0, 8'h00);
        send(1'b1, 16'h8000, 0, 8'h00);  // must decode as RUN, not data
        chk("mid_hdr_running", {31'b0, running}, 32'd1);
        chk("mid_hdr_busy",    {31'b0, busy},    32'd0);

        // Loader/CPU arbitration while the CPU streams stores.
        cpu(1'b1, 8'h01, 16'h0101);
        s_valid = 1'b1; s_data = 16'h4000;  // LOAD_D x1
        #1;
        chk("arb_pass1_addr", {24'b0, d_w_addr}, 32'h01);
        chk("arb_pass1_data", {16'b0, d_w_data}, 32'h0101);
        chk("arb_pass1_we",   {31'b0, d_we},     32'd1);
        @(negedge clk);
        chk("arb_soft_reset", {31'b0, soft_reset}, 32'd1);
        chk("arb_busy",       {31'b0, busy},       32'd1);
        cpu(1'b1, 8'h02, 16'h0202);
        s_data = 16'h0005;
        #1;
        chk("arb_pass2_addr", {24'b0, d_w_addr}, 32'h02);
        @(negedge clk);
        cpu(1'b1, 8'h03, 16'h0303);
        s_data = 16'h1234;
        #1;
        chk("arb_pass3_data", {16'b0, d_w_data}, 32'h0303);
        chk("arb_collide_pre", {31'b0, collide}, 32'd0);
        @(negedge clk);
        cpu(1'b1, 8'h04, 16'h0404);
        s_valid = 1'b0;
        #1;
        chk("arb_ld_addr", {24'b0, d_w_addr}, 32'h05);
        chk("arb_ld_data", {16'b0, d_w_data}, 32'h1234);
        chk("arb_ld_we",   {31'b0, d_we},     32'd1);
        chk("arb_ld_busy", {31'b0, busy},     32'd0);
        @(negedge clk);
        chk("arb_collide_set", {31'b0, collide}, 32'd1);
        cpu(1'b1, 8'h06, 16'h0606);
        #1;
        chk("arb_pass6_addr", {24'b0, d_w_addr}, 32'h06);
        chk("arb_pass6_data", {16'b0, d_w_data}, 32'h0606);
        @(negedge clk);
        cpu(1'b0, 8'h07, 16'h0707);
        #1;
        chk("arb_idle_we", {31'b0, d_we}, 32'd0);
        chk("arb_collide_hold1", {31'b0, collide}, 32'd1);
        repeat (2) @(negedge clk);
        chk("arb_collide_hold2", {31'b0, collide}, 32'd1);

        repeat (2) @(negedge clk);
        chk("sb_empty", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
